// File: rtl/odd_mult_loader.sv
// ---------------------------------------------------------------------------
// odd_mult_loader
// Upstream feeder for the odd-element multiplier stage. Collects a serial
// stream of WIDTH-bit words into a flat N_WORDS-slot frame and holds the
// frame stable until the multiplier takes it. Short frames (in_last before
// the final slot) leave the upper slots at zero; zero is even, so the
// multiplier ignores them.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_data    input word
//   in_valid   in_data is valid
//   in_last    in_data is the final word of a frame
//   in_ready   loader can accept a word this cycle (combinational)
//   arr        packed frame; slot i = arr[(i+1)*WIDTH-1 : i*WIDTH]
//   arr_valid  arr holds a complete frame
//   arr_ready  downstream consumes arr this cycle
//   frame_len  number of real (non-pad) words in arr
//   odd_cnt    number of words in arr with bit0 = 1
// ---------------------------------------------------------------------------
module odd_mult_loader #(
    parameter int N_WORDS = 5,
    parameter int WIDTH   = 32,
    localparam int CW     = $clog2(N_WORDS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [N_WORDS*WIDTH-1:0]   arr,
    output logic                       arr_valid,
    input  logic                       arr_ready,
    output logic [CW-1:0]              frame_len,
    output logic [CW-1:0]              odd_cnt
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(N_WORDS - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] ZERO     = {CW{1'b0}};

    state_t                   state_r, state_s;
    logic [CW-1:0]            idx_r, idx_s;
    logic [N_WORDS*WIDTH-1:0] arr_r, arr_s;
    logic                     arr_valid_r, arr_valid_s;
    logic [CW-1:0]            frame_len_r, frame_len_s;
    logic [CW-1:0]            odd_cnt_r, odd_cnt_s;
    logic                     in_ready_s;
    logic                     accept_s;

    // Ready is purely a function of state so upstream never sees a loop through in_valid.
    always_comb begin
        in_ready_s = (state_r == FILL) && !rst;
        accept_s   = in_valid && in_ready_s;
    end

    assign in_ready  = in_ready_s;
    assign arr       = arr_r;
    assign arr_valid = arr_valid_r;
    assign frame_len = frame_len_r;
    assign odd_cnt   = odd_cnt_r;

    // Next-state and datapath update: fill slots in FILL, hold until released in HOLD.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        arr_s       = arr_r;
        arr_valid_s = arr_valid_r;
        frame_len_s = frame_len_r;
        odd_cnt_s   = odd_cnt_r;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    for (int i = 0; i < N_WORDS; i++) begin
                        if (idx_r == CW'(i)) begin
                            arr_s[i*WIDTH +: WIDTH] = in_data;
                        end else begin
                            arr_s[i*WIDTH +: WIDTH] = arr_r[i*WIDTH +: WIDTH];
                        end
                    end
                    frame_len_s = idx_r + ONE;
                    odd_cnt_s   = odd_cnt_r + {{(CW-1){1'b0}}, in_data[0]};
                    // A full frame closes on its last slot regardless of in_last.
                    if (in_last || (idx_r == LAST_IDX)) begin
                        state_s     = HOLD;
                        arr_valid_s = 1'b1;
                    end else begin
                        idx_s = idx_r + ONE;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            HOLD: begin
                // Release clears the buffer so the next short frame is zero-padded.
                if (arr_ready) begin
                    state_s     = FILL;
                    idx_s       = ZERO;
                    arr_s       = {(N_WORDS*WIDTH){1'b0}};
                    arr_valid_s = 1'b0;
                    frame_len_s = ZERO;
                    odd_cnt_s   = ZERO;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s     = FILL;
                idx_s       = ZERO;
                arr_s       = {(N_WORDS*WIDTH){1'b0}};
                arr_valid_s = 1'b0;
                frame_len_s = ZERO;
                odd_cnt_s   = ZERO;
            end
        endcase
    end

    // State and output registers with synchronous reset that discards any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FILL;
            idx_r       <= ZERO;
            arr_r       <= {(N_WORDS*WIDTH){1'b0}};
            arr_valid_r <= 1'b0;
            frame_len_r <= ZERO;
            odd_cnt_r   <= ZERO;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            arr_r       <= arr_s;
            arr_valid_r <= arr_valid_s;
            frame_len_r <= frame_len_s;
            odd_cnt_r   <= odd_cnt_s;
        end
    end

endmodule

// File: tb/tb_odd_mult_loader.sv
// ---------------------------------------------------------------------------
// tb_odd_mult_loader
// Self-checking bench for odd_mult_loader. A frame-level model (a queue of
// accepted words plus a "frame held" flag) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_odd_mult_loader;

    localparam int N  = 5;
    localparam int W  = 32;
    localparam int CW = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [N*W-1:0] arr;
    logic           arr_valid;
    logic           arr_ready;
    logic [CW-1:0]  frame_len;
    logic [CW-1:0]  odd_cnt;

    always #5 clk = ~clk;

    odd_mult_loader #(.N_WORDS(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .arr       (arr),
        .arr_valid (arr_valid),
        .arr_ready (arr_ready),
        .frame_len (frame_len),
        .odd_cnt   (odd_cnt)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model: words of the current frame, and whether it is complete.
    int unsigned words[$];
    bit          held = 1'b0;

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] model_arr();
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < words.size(); i++) r[i*W +: W] = words[i];
        return r;
    endfunction

    function automatic int model_odd();
        int c;
        c = 0;
        foreach (words[i]) c += int'(words[i] & 32'd1);
        return c;
    endfunction

    function automatic longint unsigned odd_product(input logic [N*W-1:0] a);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < N; i++) if (a[i*W]) p = p * a[i*W +: W];
        return p;
    endfunction

    // One clock cycle: drive, check in_ready, advance model at the edge, check registers.
    task automatic cyc(input bit v, input logic [W-1:0] d, input bit l, input bit ar, input bit r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        arr_ready = ar;
        rst       = r;
        #3;
        chk("in_ready", in_ready, (!r && !held));
        @(posedge clk);
        if (r) begin
            words.delete();
            held = 1'b0;
        end else if (!held) begin
            if (v) begin
                words.push_back(d);
                if (l || words.size() == N) held = 1'b1;
            end
        end else if (ar) begin
            words.delete();
            held = 1'b0;
        end
        #1;
        chk("arr",       arr,       model_arr());
        chk("arr_valid", arr_valid, held);
        chk("frame_len", frame_len, words.size());
        chk("odd_cnt",   odd_cnt,   model_odd());
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; arr_ready = 1'b0;
        @(posedge clk); #1;

        // Reset state
        cyc(1'b1, 32'd5, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

        // T1 full frame, arr_ready high
        for (int w = 3; w <= 7; w++) cyc(1'b1, W'(w), 1'b0, 1'b1, 1'b0);
        chk("t1_arr", arr, {32'd7, 32'd6, 32'd5, 32'd4, 32'd3});
        chk("t1_prod", odd_product(arr), 64'd105);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("t1_valid_one_cycle", arr_valid, 1'b0);

        // T2 short frame
        cyc(1'b1, 32'd9, 1'b1, 1'b0, 1'b0);
        chk("t2_arr", arr, {32'd0, 32'd0, 32'd0, 32'd0, 32'd9});
        chk("t2_len", frame_len, 3'd1);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // T3 backpressure with in_valid held high
        for (int w = 0; w < N; w++) cyc(1'b1, W'(20 + w), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        chk("t3_arr_stable", arr, {32'd24, 32'd23, 32'd22, 32'd21, 32'd20});
        cyc(1'b1, 32'd42, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'd77, 1'b1, 1'b1, 1'b0);
        chk("t3_slot0", arr, {128'd0, 32'd77});
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // T4 reset mid-fill
        cyc(1'b1, 32'd2,  1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'd11, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0,  1'b0, 1'b0, 1'b1);
        chk("t4_arr_cleared", arr, {(N*W){1'b0}});
        cyc(1'b1, 32'd1,  1'b1, 1'b0, 1'b0);
        chk("t4_arr", arr, {128'd0, 32'd1});
        chk("t4_len", frame_len, 3'd1);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // T5 gapped input
        for (int i = 0; i < N; i++) begin
            cyc(1'b1, W'(2*i + 1), 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 32'hdead_beef, 1'b1, 1'b0, 1'b0);
        end
        chk("t5_odd", odd_cnt, 3'd5);
        chk("t5_prod", odd_product(arr), 64'd945);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // T6 back-to-back frames, both sides streaming
        for (int i = 0; i < 3*(N+1); i++) cyc(1'b1, W'(100 + i), 1'b0, 1'b1, 1'b0);

        // Randomised traffic including occasional resets
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
